mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data/address width; legal values are 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 5, register-file address width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port rf_we_i  in  1  register-file write enable from EXE.
REQ-006 SHALL have port mem_we_i  in  1  store request.
REQ-007 SHALL have port mem2rf_i  in  1  load request (writeback selects memory data).
REQ-008 SHALL have port mem_size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 dword.
REQ-009 SHALL have port mem_unsigned_i  in  1  zero-extend load when 1, sign-extend when 0.
REQ-010 SHALL have port mem_wdata_i  in  DATA_W  store data, right-aligned.
REQ-011 SHALL have port rf_waddr_i  in  ADDR_W  destination register.
REQ-012 SHALL have port alu_result_i  in  DATA_W  effective address / ALU result.
REQ-013 SHALL have port latch_en  in  1  advance the output pipeline latch.
REQ-014 SHALL have port latch_clear  in  1  zero the output pipeline latch; priority over latch_en.
REQ-015 SHALL have port dmem_req_o  out  1  data-memory request.
REQ-016 SHALL have port dmem_we_o  out  1  request is a write.
REQ-017 SHALL have port dmem_addr_o  out  DATA_W  address with low offset bits forced to 0.
REQ-018 SHALL have port dmem_wdata_o  out  DATA_W  store data replicated into every byte lane of its size.
REQ-019 SHALL have port dmem_be_o  out  DATA_W/8  byte enables.
REQ-020 SHALL have port dmem_ack_i  in  1  request accepted; read data valid in the same cycle.
REQ-021 SHALL have port dmem_rdata_i  in  DATA_W  read data.
REQ-022 SHALL have ports rf_we_o, rf_waddr_o, mem2rf_o, alu_result_o  out  1/ADDR_W/1/DATA_W  latched copies of the inputs, to WB.
REQ-023 SHALL have port mem_rdata_o  out  DATA_W  latched, extracted and extended load data, to WB.
REQ-024 SHALL have ports rf_data_o, rf_dst_o, rf_we_hu_o  out  DATA_W/ADDR_W/1  combinational copies of alu_result_i, rf_waddr_i and rf_we_i, for bypass.
REQ-025 SHALL have port stall_o  out  1  hazard unit must freeze stages up to and including EXE.
REQ-026 SHALL have port misalign_o  out  1  latched misaligned-access flag; exists only with the macro.

Function
REQ-027 SHALL implement FSM IDLE, WAIT and HOLD; access = (mem_we_i | mem2rf_i) & ~blocked.
REQ-028 In IDLE and WAIT, dmem_req_o SHALL equal access, and stall_o SHALL equal access & ~dmem_ack_i.
REQ-029 Transitions SHALL be: IDLE->WAIT on access & ~ack; WAIT->IDLE on ack & latch_en; IDLE/WAIT->HOLD on ack & ~latch_en; HOLD->IDLE on latch_en.
REQ-030 The stage SHALL capture extended read data in a buffer on entry to HOLD; in HOLD dmem_req_o=0, stall_o=0, and the buffer feeds mem_rdata_o.
REQ-031 A zero-wait access (ack in the request cycle) SHALL add no stall cycle.
REQ-032 Byte offset SHALL be alu_result_i[log2(DATA_W/8)-1:0]; dmem_be_o SHALL be the (1<<size)-byte mask shifted left by offset; dword SHALL be treated as word when DATA_W=32.
REQ-033 Load data SHALL be dmem_rdata_i shifted right by offset*8, truncated to size, then sign- or zero-extended to DATA_W.
REQ-034 Output latches SHALL update on latch_en, SHALL be zeroed on latch_clear, and SHALL hold otherwise; latch_clear SHALL NOT abort an outstanding request.

Reset
REQ-035 Reset low SHALL force FSM to IDLE, zero all latched outputs and the buffer, and deassert dmem_req_o immediately, including mid-WAIT.

Configuration
REQ-036 With MEM_MISALIGN_TRAP_EN defined, blocked = offset not a multiple of the size in bytes; a blocked access SHALL issue no request and SHALL set misalign_o=1 in the latch.
REQ-037 Without MEM_MISALIGN_TRAP_EN, blocked=0, misalign_o SHALL be absent, and misaligned accesses SHALL proceed with lanes that fall off the word dropped.

Verification
REQ-038 LB, addr 0x103, rdata 0x80FF_FF7F, ack same cycle -> no stall; mem_rdata_o=0xFFFF_FF80 after latch_en.
REQ-039 LHU, addr 0x102, ack after 3 cycles -> stall_o high for 3 cycles, req held; mem_rdata_o=0x0000_80FF.
REQ-040 SB, addr 0x101, wdata 0xAB -> dmem_be_o=0010, dmem_wdata_o=0xABAB_ABAB, dmem_we_o=1.
REQ-041 Ack with latch_en=0 for 2 cycles -> HOLD, req low; buffered data appears when latch_en rises.
REQ-042 Reset asserted in WAIT -> req low immediately, outputs 0; with the macro, LW at 0x102 -> no req, misalign_o=1.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage.
// Issues data-memory requests for loads and stores, steers store data and
// byte enables, extracts and extends load data, and latches results for WB.
// Optional feature: define MEM_MISALIGN_TRAP_EN to block misaligned accesses
// and report them through the latched misalign_o flag.
//
// state  | meaning
// IDLE   | no access outstanding; zero-wait accesses complete here
// WAIT   | request issued, waiting for dmem_ack_i
// HOLD   | acked but WB latch not advancing; read data parked in buffer
module mem_access_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rf_we_i,
    input  logic                  mem_we_i,
    input  logic                  mem2rf_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  mem_unsigned_i,
    input  logic [DATA_W-1:0]     mem_wdata_i,
    input  logic [ADDR_W-1:0]     rf_waddr_i,
    input  logic [DATA_W-1:0]     alu_result_i,
    input  logic                  latch_en,
    input  logic                  latch_clear,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_W-1:0]     dmem_addr_o,
    output logic [DATA_W-1:0]     dmem_wdata_o,
    output logic [DATA_W/8-1:0]   dmem_be_o,
    input  logic                  dmem_ack_i,
    input  logic [DATA_W-1:0]     dmem_rdata_i,
    output logic                  rf_we_o,
    output logic [ADDR_W-1:0]     rf_waddr_o,
    output logic                  mem2rf_o,
    output logic [DATA_W-1:0]     alu_result_o,
    output logic [DATA_W-1:0]     mem_rdata_o,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                  misalign_o,
`endif
    output logic [DATA_W-1:0]     rf_data_o,
    output logic [ADDR_W-1:0]     rf_dst_o,
    output logic                  rf_we_hu_o,
    output logic                  stall_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t              state_q, state_d;
    logic [OFF_W-1:0]    offset;
    logic [1:0]          size_eff;
    logic [BE_W-1:0]     be_mask;
    logic [DATA_W-1:0]   wdata_rep;
    logic [DATA_W-1:0]   rd_shift;
    logic [DATA_W-1:0]   rd_top;
    logic [DATA_W-1:0]   load_ext;
    logic [6:0]          ext_sh;
    logic                blocked;
    logic                access;
    logic                in_hold;

    logic [DATA_W-1:0]   buf_q, buf_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic                mem2rf_q, mem2rf_d;
    logic [DATA_W-1:0]   alu_result_q, alu_result_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

    assign offset   = alu_result_i[OFF_W-1:0];
    // A 32-bit datapath has no dword lanes, so dword degrades to word.
    assign size_eff = (DATA_W == 32 && mem_size_i == 2'b11) ? 2'b10 : mem_size_i;

`ifdef MEM_MISALIGN_TRAP_EN
    logic [3:0] size_bytes;
    logic       misalign_q, misalign_d;
    assign size_bytes = 4'd1 << size_eff;
    assign blocked    = (mem_we_i | mem2rf_i) &&
                        ((offset & OFF_W'(size_bytes - 4'd1)) != '0);
`else
    assign blocked = 1'b0;
`endif

    assign access  = (mem_we_i | mem2rf_i) & ~blocked;
    assign in_hold = (state_q == S_HOLD);

    // Reset gates the request combinationally so it drops without a clock.
    assign dmem_req_o   = reset & access & ~in_hold;
    assign stall_o      = dmem_req_o & ~dmem_ack_i;
    assign dmem_we_o    = dmem_req_o & mem_we_i;
    assign dmem_addr_o  = {alu_result_i[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
    // Lanes shifted past the top of the word are simply dropped.
    assign dmem_be_o    = be_mask << offset;
    assign dmem_wdata_o = wdata_rep;

    assign rf_data_o  = alu_result_i;
    assign rf_dst_o   = rf_waddr_i;
    assign rf_we_hu_o = rf_we_i;

    // Byte-enable mask for the access size, before lane shifting.
    always_comb begin
        case (size_eff)
            2'b00:   be_mask = BE_W'(8'h01);
            2'b01:   be_mask = BE_W'(8'h03);
            2'b10:   be_mask = BE_W'(8'h0F);
            default: be_mask = BE_W'(8'hFF);
        endcase
    end

    // Replicate store data across every lane of its size.
    always_comb begin
        case (size_eff)
            2'b00:   wdata_rep = {BE_W{mem_wdata_i[7:0]}};
            2'b01:   wdata_rep = {(BE_W/2){mem_wdata_i[15:0]}};
            2'b10:   wdata_rep = {(BE_W/4){mem_wdata_i[31:0]}};
            default: wdata_rep = mem_wdata_i;
        endcase
    end

    assign rd_shift = dmem_rdata_i >> {offset, 3'b000};
    assign ext_sh   = 7'(DATA_W) - (7'd8 << size_eff);

    // Truncate to size by shifting to the top, then shift back to extend.
    always_comb begin
        rd_top = rd_shift << ext_sh;
        if (mem_unsigned_i) begin
            load_ext = rd_top >> ext_sh;
        end else begin
            load_ext = $signed(rd_top) >>> ext_sh;
        end
    end

    // Next-state logic; latch_clear deliberately has no effect here.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (access && dmem_ack_i && !latch_en) begin
                    state_d = S_HOLD;
                end else if (access && !dmem_ack_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (access && dmem_ack_i) begin
                    state_d = latch_en ? S_IDLE : S_HOLD;
                end else if (!access) begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (latch_en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Buffer and output-latch next values.
    always_comb begin
        buf_d        = buf_q;
        rf_we_d      = rf_we_q;
        rf_waddr_d   = rf_waddr_q;
        mem2rf_d     = mem2rf_q;
        alu_result_d = alu_result_q;
        mem_rdata_d  = mem_rdata_q;
        if (!in_hold && state_d == S_HOLD) begin
            buf_d = load_ext;
        end
        if (latch_clear) begin
            rf_we_d      = 1'b0;
            rf_waddr_d   = '0;
            mem2rf_d     = 1'b0;
            alu_result_d = '0;
            mem_rdata_d  = '0;
        end else if (latch_en) begin
            rf_we_d      = rf_we_i;
            rf_waddr_d   = rf_waddr_i;
            mem2rf_d     = mem2rf_i;
            alu_result_d = alu_result_i;
            mem_rdata_d  = in_hold ? buf_q : load_ext;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Misalign flag travels with the rest of the WB latch.
    always_comb begin
        misalign_d = misalign_q;
        if (latch_clear) begin
            misalign_d = 1'b0;
        end else if (latch_en) begin
            misalign_d = blocked;
        end
    end

    // Misalign flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;
`endif

    // State, buffer and WB latch registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            mem2rf_q     <= 1'b0;
            alu_result_q <= '0;
            mem_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            mem2rf_q     <= mem2rf_d;
            alu_result_q <= alu_result_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    assign rf_we_o      = rf_we_q;
    assign rf_waddr_o   = rf_waddr_q;
    assign mem2rf_o     = mem2rf_q;
    assign alu_result_o = alu_result_q;
    assign mem_rdata_o  = mem_rdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and randomized checks of mem_access_stage
// (DATA_W=32) against a byte-lane reference model.
module tb_mem_access_stage;

    logic        clk, reset;
    logic        rf_we_i, mem_we_i, mem2rf_i, mem_unsigned_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_wdata_i, alu_result_i, dmem_rdata_i;
    logic [4:0]  rf_waddr_i;
    logic        latch_en, latch_clear, dmem_ack_i;
    logic        dmem_req_o, dmem_we_o, stall_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        rf_we_o, mem2rf_o, rf_we_hu_o;
    logic [4:0]  rf_waddr_o, rf_dst_o;
    logic [31:0] alu_result_o, mem_rdata_o, rf_data_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    mem_access_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .rf_we_i(rf_we_i), .mem_we_i(mem_we_i), .mem2rf_i(mem2rf_i),
        .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
        .mem_wdata_i(mem_wdata_i), .rf_waddr_i(rf_waddr_i),
        .alu_result_i(alu_result_i), .latch_en(latch_en), .latch_clear(latch_clear),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .mem2rf_o(mem2rf_o),
        .alu_result_o(alu_result_o), .mem_rdata_o(mem_rdata_o),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_o(misalign_o),
`endif
        .rf_data_o(rf_data_o), .rf_dst_o(rf_dst_o), .rf_we_hu_o(rf_we_hu_o),
        .stall_o(stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---- reference model: byte-lane arithmetic on a 4-byte word ----
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b11) ? 4 : (1 << sz);
    endfunction

    function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [1:0] sz);
        logic [3:0] be;
        int off;
        be = '0;
        off = int'(a % 4);
        for (int i = 0; i < nbytes(sz); i++)
            if (off + i < 4) be[off + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] w, input logic [1:0] sz);
        logic [31:0] v;
        int n;
        n = nbytes(sz);
        for (int i = 0; i < 4; i++) v[8*i +: 8] = w[8*(i % n) +: 8];
        return v;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        int off, n;
        v = '0;
        off = int'(a % 4);
        n = nbytes(sz);
        for (int i = 0; i < n; i++)
            if (off + i < 4) v[8*i +: 8] = rd[8*(off + i) +: 8];
        if (!uns && v[8*n - 1])
            for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic ref_blocked(input logic [31:0] a, input logic [1:0] sz);
`ifdef MEM_MISALIGN_TRAP_EN
        return ((a % 4) % nbytes(sz)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_op(input logic st, input logic ld, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] w);
        mem_we_i = st; mem2rf_i = ld; mem_size_i = sz;
        mem_unsigned_i = uns; alu_result_i = a; mem_wdata_i = w;
    endtask

    task automatic idle_in();
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        rf_we_i = 1'b0; rf_waddr_i = '0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
        latch_en = 1'b0; latch_clear = 1'b0;
    endtask

    logic        r_st, r_ld, r_uns, r_blk, r_acc, r_we;
    logic [1:0]  r_sz;
    logic [31:0] r_a, r_w, r_rd;
    logic [4:0]  r_wa;
    int          r_waits;

    initial begin
        reset = 1'b0;
        idle_in();
        #12;
        chk1("rst_req", dmem_req_o, 1'b0);
        chk1("rst_stall", stall_o, 1'b0);
        chk1("rst_rf_we", rf_we_o, 1'b0);
        chk32("rst_rdata", mem_rdata_o, 32'h0);
        chk32("rst_alu", alu_result_o, 32'h0);
        @(negedge clk) reset = 1'b1;

        // LB at 0x103, zero-wait
        @(negedge clk);
        set_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h0);
        rf_we_i = 1'b1; rf_waddr_i = 5'd7; dmem_rdata_i = 32'h80FF_FF7F;
        dmem_ack_i = 1'b1; latch_en = 1'b1;
        #1;
        chk1("lb_req", dmem_req_o, 1'b1);
        chk1("lb_stall", stall_o, 1'b0);
        chk32("lb_be", 32'(dmem_be_o), 32'h8);
        chk32("lb_addr", dmem_addr_o, 32'h100);
        chk32("lb_byp_data", rf_data_o, 32'h103);
        chk32("lb_byp_dst", 32'(rf_dst_o), 32'd7);
        chk1("lb_byp_we", rf_we_hu_o, 1'b1);
        @(posedge clk); #1;
        chk32("lb_rdata", mem_rdata_o, 32'hFFFF_FF80);
        chk1("lb_rf_we", rf_we_o, 1'b1);
        chk32("lb_waddr", 32'(rf_waddr_o), 32'd7);
        chk1("lb_mem2rf", mem2rf_o, 1'b1);
        chk32("lb_alu", alu_result_o, 32'h103);

        // LHU at 0x102, ack after 3 cycles
        @(negedge clk);
        set_op(1'b0, 1'b1, 2'b01, 1'b1, 32'h102, 32'h0);
        rf_waddr_i = 5'd9; dmem_rdata_i = 32'h80FF_1234; dmem_ack_i = 1'b0; latch_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk1("lhu_stall", stall_o, 1'b1);
            chk1("lhu_req", dmem_req_o, 1'b1);
            chk32("lhu_hold_latch", mem_rdata_o, 32'hFFFF_FF80);
            @(negedge clk);
        end
        dmem_ack_i = 1'b1; latch_en = 1'b1;
        #1;
        chk1("lhu_ack_stall", stall_o, 1'b0);
        chk1("lhu_ack_req", dmem_req_o, 1'b1);
        @(posedge clk); #1;
        chk32("lhu_rdata", mem_rdata_o, 32'h0000_80FF);
        chk32("lhu_waddr", 32'(rf_waddr_o), 32'd9);

        // SB at 0x101
        @(negedge clk);
        set_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0000_00AB);
        rf_we_i = 1'b0; dmem_rdata_i = 32'h0; dmem_ack_i = 1'b1; latch_en = 1'b1;
        #1;
        chk32("sb_be", 32'(dmem_be_o), 32'h2);
        chk32("sb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
        chk1("sb_we", dmem_we_o, 1'b1);
        chk1("sb_stall", stall_o, 1'b0);
        @(posedge clk); #1;
        chk1("sb_mem2rf", mem2rf_o, 1'b0);

        // LW acked while latch_en low -> HOLD for 2 cycles
        @(negedge clk);
        set_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h200, 32'h0);
        dmem_rdata_i = 32'hDEAD_BEEF; dmem_ack_i = 1'b1; latch_en = 1'b0;
        #1;
        chk1("hold_ack_req", dmem_req_o, 1'b1);
        chk1("hold_ack_stall", stall_o, 1'b0);
        @(negedge clk);
        dmem_ack_i = 1'b0; dmem_rdata_i = 32'h1234_5678;
        #1;
        chk1("hold_req", dmem_req_o, 1'b0);
        chk1("hold_stall", stall_o, 1'b0);
        chk32("hold_latch", mem_rdata_o, 32'h0);
        @(negedge clk);
        latch_en = 1'b1;
        #1;
        chk1("hold_req2", dmem_req_o, 1'b0);
        @(posedge clk); #1;
        chk32("hold_rdata", mem_rdata_o, 32'hDEAD_BEEF);
        chk32("hold_alu", alu_result_o, 32'h200);

        // latch_clear during WAIT zeros latch but keeps the request alive
        @(negedge clk);
        set_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h300, 32'h0);
        dmem_rdata_i = 32'h1122_3344; dmem_ack_i = 1'b0; latch_en = 1'b0; latch_clear = 1'b1;
        #1;
        chk1("clr_stall", stall_o, 1'b1);
        @(posedge clk); #1;
        chk32("clr_rdata", mem_rdata_o, 32'h0);
        chk32("clr_alu", alu_result_o, 32'h0);
        @(negedge clk);
        latch_clear = 1'b0;
        #1;
        chk1("clr_req_kept", dmem_req_o, 1'b1);
        dmem_ack_i = 1'b1; latch_en = 1'b1;
        @(posedge clk); #1;
        chk32("clr_then_rdata", mem_rdata_o, 32'h1122_3344);

        // latch_clear wins over latch_en
        @(negedge clk);
        latch_clear = 1'b1; rf_we_i = 1'b1;
        @(posedge clk); #1;
        chk32("clrpri_rdata", mem_rdata_o, 32'h0);
        chk1("clrpri_rf_we", rf_we_o, 1'b0);

        // reset asserted mid-WAIT
        @(negedge clk);
        latch_clear = 1'b0;
        set_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'h0);
        dmem_rdata_i = 32'h5555_AAAA; dmem_ack_i = 1'b1; latch_en = 1'b1;
        @(posedge clk); #1;
        chk32("pre_rst_rdata", mem_rdata_o, 32'h5555_AAAA);
        @(negedge clk);
        dmem_ack_i = 1'b0; latch_en = 1'b0;
        @(posedge clk); #1;
        chk1("wait_stall", stall_o, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk1("rst_wait_req", dmem_req_o, 1'b0);
        chk1("rst_wait_stall", stall_o, 1'b0);
        chk32("rst_wait_rdata", mem_rdata_o, 32'h0);
        chk32("rst_wait_alu", alu_result_o, 32'h0);
        chk1("rst_wait_rf_we", rf_we_o, 1'b0);
        @(negedge clk);
        idle_in();
        reset = 1'b1;
        #1;
        chk1("post_rst_req", dmem_req_o, 1'b0);

`ifdef MEM_MISALIGN_TRAP_EN
        // misaligned LW is blocked and flagged
        @(negedge clk);
        set_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h102, 32'h0);
        dmem_ack_i = 1'b0; latch_en = 1'b1;
        #1;
        chk1("mis_req", dmem_req_o, 1'b0);
        chk1("mis_stall", stall_o, 1'b0);
        @(posedge clk); #1;
        chk1("mis_flag", misalign_o, 1'b1);
        @(negedge clk);
        idle_in();
`endif

        // randomized accesses with 0..2 wait cycles
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            case ($urandom_range(0, 2))
                0: begin r_ld = 1'b1; r_st = 1'b0; end
                1: begin r_ld = 1'b0; r_st = 1'b1; end
                default: begin r_ld = 1'b0; r_st = 1'b0; end
            endcase
            r_sz = 2'($urandom_range(0, 3));
            r_uns = 1'($urandom_range(0, 1));
            r_a = $urandom; r_w = $urandom; r_rd = $urandom;
            r_we = 1'($urandom_range(0, 1)); r_wa = 5'($urandom_range(0, 31));
            r_blk = (r_ld | r_st) & ref_blocked(r_a, r_sz);
            r_acc = (r_ld | r_st) & ~r_blk;
            r_waits = r_acc ? int'($urandom_range(0, 2)) : 0;
            set_op(r_st, r_ld, r_sz, r_uns, r_a, r_w);
            rf_we_i = r_we; rf_waddr_i = r_wa; dmem_rdata_i = r_rd;
            for (int w = 0; w <= r_waits; w++) begin
                if (w > 0) @(negedge clk);
                dmem_ack_i = (w == r_waits);
                latch_en = (w == r_waits);
                #1;
                chk1("rnd_req", dmem_req_o, r_acc);
                chk1("rnd_stall", stall_o, r_acc && (w < r_waits));
                if (w == r_waits) begin
                    chk32("rnd_be", 32'(dmem_be_o), 32'(ref_be(r_a, r_sz)));
                    chk32("rnd_wdata", dmem_wdata_o, ref_wdata(r_w, r_sz));
                    chk32("rnd_addr", dmem_addr_o, r_a & 32'hFFFF_FFFC);
                    chk1("rnd_dwe", dmem_we_o, r_acc & r_st);
                    chk32("rnd_byp", rf_data_o, r_a);
                end
            end
            @(posedge clk); #1;
            chk32("rnd_alu", alu_result_o, r_a);
            chk1("rnd_rf_we", rf_we_o, r_we);
            chk32("rnd_waddr", 32'(rf_waddr_o), 32'(r_wa));
            chk1("rnd_mem2rf", mem2rf_o, r_ld);
            if (r_ld && !r_blk)
                chk32("rnd_rdata", mem_rdata_o, ref_load(r_rd, r_a, r_sz, r_uns));
`ifdef MEM_MISALIGN_TRAP_EN
            chk1("rnd_misalign", misalign_o, r_blk);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
